// File: rtl/text_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// text_cmd_scheduler
// Collects 32-bit commands from two requesters (A: host/CPU, B: frame
// animation), arbitrates them round-robin into a shared FIFO and issues each
// one to text_area8x8 as a single-cycle strobe, only while the display is
// blanked. Commands whose opcode equals DEFER_OP (e.g. scroll) are held until
// vertical blank. Single clock domain (pixel clock).
//
// Ports:
//   i_pix_clk            pixel clock
//   i_rst                asynchronous active-high reset
//   i_a_valid/i_a_data   requester A command offer
//   o_a_ready            A transfer happens when i_a_valid & o_a_ready
//   i_b_valid/i_b_data   requester B command offer
//   o_b_ready            B transfer happens when i_b_valid & o_b_ready
//   i_blank              display not active (h or v blank)
//   i_vblank             vertical blank interval
//   o_cmd_clk            one-cycle issue strobe
//   o_cmd_data           command, stable from ARM through end of GAP
//   o_level              FIFO occupancy
//   o_busy               FIFO non-empty or sequencer not idle
//
// Build option:
//   TXT_CMD_COALESCE_EN  when defined, a not-yet-eligible deferred command in
//                        ARM is replaced by a same-opcode FIFO head (latest
//                        wins), so a burst of scrolls yields one strobe.
// ---------------------------------------------------------------------------
module text_cmd_scheduler #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DW         = 32,
    parameter logic [3:0]  DEFER_OP   = 4'b0011,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                   i_pix_clk,
    input  logic                   i_rst,
    input  logic                   i_a_valid,
    input  logic [DW-1:0]          i_a_data,
    output logic                   o_a_ready,
    input  logic                   i_b_valid,
    input  logic [DW-1:0]          i_b_data,
    output logic                   o_b_ready,
    input  logic                   i_blank,
    input  logic                   i_vblank,
    output logic                   o_cmd_clk,
    output logic [DW-1:0]          o_cmd_data,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        PULSE = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t        state;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          rr_b;
    logic [GW-1:0] gap_cnt;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          take_a;
    logic          eligible;
    logic          coalesce;
    logic [DW-1:0] push_data;
    logic [DW-1:0] head;

    assign full  = (count == LW'(DEPTH));
    assign empty = (count == LW'(0));
    assign head  = mem[rd_ptr];

    // Round-robin arbiter; with no request the pointer port is pre-granted.
    always_comb begin
        o_a_ready = 1'b0;
        o_b_ready = 1'b0;
        if (!full) begin
            if (i_a_valid && !i_b_valid) begin
                o_a_ready = 1'b1;
            end else if (i_b_valid && !i_a_valid) begin
                o_b_ready = 1'b1;
            end else begin
                o_a_ready = !rr_b;
                o_b_ready = rr_b;
            end
        end
    end

    assign take_a    = i_a_valid & o_a_ready;
    assign push      = take_a | (i_b_valid & o_b_ready);
    assign push_data = take_a ? i_a_data : i_b_data;

    // Held command may issue only in blank; deferred opcode also needs vblank.
    assign eligible = i_blank & ((o_cmd_data[DW-1 -: 4] != DEFER_OP) | i_vblank);

`ifdef TXT_CMD_COALESCE_EN
    // Replace a waiting deferred command with a newer one of the same opcode.
    assign coalesce = (state == ARM) & !eligible & !empty
                    & (o_cmd_data[DW-1 -: 4] == DEFER_OP)
                    & (head[DW-1 -: 4] == DEFER_OP);
`else
    assign coalesce = 1'b0;
`endif

    assign pop = ((state == IDLE) & !empty) | coalesce;

    // FIFO storage (no reset needed; occupancy is tracked by count).
    always_ff @(posedge i_pix_clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // FIFO pointers, occupancy and round-robin pointer.
    always_ff @(posedge i_pix_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr_b   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + LW'(1);
            end else if (pop && !push) begin
                count <= count - LW'(1);
            end
            // Pointer only moves when a real contention was resolved.
            if (push && i_a_valid && i_b_valid) begin
                rr_b <= ~rr_b;
            end
        end
    end

    // Issue sequencer: IDLE -> ARM -> PULSE -> GAP -> IDLE.
    always_ff @(posedge i_pix_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            o_cmd_clk  <= 1'b0;
            o_cmd_data <= '0;
            gap_cnt    <= '0;
        end else begin
            o_cmd_clk <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        o_cmd_data <= head;
                        state      <= ARM;
                    end
                end
                ARM: begin
                    if (eligible) begin
                        o_cmd_clk <= 1'b1;
                        state     <= PULSE;
                    end else if (coalesce) begin
                        o_cmd_data <= head;
                    end
                end
                PULSE: begin
                    gap_cnt <= GW'(GAP_CYCLES);
                    state   <= GAP;
                end
                GAP: begin
                    gap_cnt <= gap_cnt - GW'(1);
                    if (gap_cnt == GW'(1)) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign o_level = count;
    assign o_busy  = !empty | (state != IDLE);

endmodule
